alu_mul_seq: RTL
================

Name: alu_mul_seq

Overview:
- Multi-cycle sequencer for RV32M MUL (low 32 bits of rs1*rs2) built on the shared EX-stage ALU.
- Performs shift-add multiplication by borrowing the ALU for one ADD per iteration.
- Sits beside the EX stage. While it holds `alu_own`, the top level routes its operands into the ALU with B-select forced to register. `busy` stalls IF/ID/EX.
- Early termination is based on the multiplier's most significant set bit.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 6, iteration counter width (must hold WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request pulse from EX decode. Sampled only in IDLE.
- flush  in  1  pipeline flush; aborts any operation.
- rs1  in  WIDTH  multiplicand, sampled with start.
- rs2  in  WIDTH  multiplier, sampled with start.
- busy  out  1  high in RUN and DONE; drives pipeline stall.
- done  out  1  one-cycle pulse; result valid.
- result  out  WIDTH  product low bits. Held until the next accepted start.
- alu_own  out  1  sequencer owns the ALU this cycle.
- alu_op  out  4  ALU opcode. `ADD when alu_own=1, else 4'b0.
- alu_a  out  WIDTH  ALU A operand (accumulator).
- alu_b  out  WIDTH  ALU B operand (shifted multiplicand).
- alu_c  in  WIDTH  ALU result C. Combinational, same cycle.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE; busy=0, done=0, result=0, alu_own=0, alu_op=0, alu_a=0, alu_b=0. Internal acc/mc/mp/cnt=0.
- States: IDLE, RUN, DONE (localparam encoding).
- IDLE:
  - start=1 and flush=0: latch acc=0, mc=rs1, mp=rs2, cnt=0.
  - Next state is RUN if rs2!=0, else DONE.
  - start=0: stay.
- RUN, each cycle:
  - alu_own=1, alu_op=`ADD, alu_a=acc, alu_b=mc.
  - If mp[0]=1: acc<=alu_c.
  - Always: mc<=mc<<1, mp<=mp>>1, cnt<=cnt+1.
  - Go to DONE when (mp>>1)==0 or cnt==WIDTH-1; else stay.
- DONE, one cycle: done=1, busy=1; result<=acc is registered on entry so it is valid while done=1. Next state IDLE.
- Latency: start sampled at edge 0 → done high in cycle 1+N.
  - N = (index of highest set bit of rs2)+1; N=0 when rs2=0.
  - Max 33 cycles.
- alu_a/alu_b are driven 0 when alu_own=0.
- Arithmetic is modulo 2^WIDTH; the ALU carry-out is discarded. Signed and unsigned MUL give identical low bits, so there is no sign handling.
- start while busy=1: ignored, no queueing.
- flush=1 in any state: next state IDLE; done suppressed; result not updated (keeps previous value). Flush has priority over start in the same cycle.
- rst mid-operation: all state and outputs return to reset values on the next edge.
- busy deasserts in the cycle after done. start in that cycle (IDLE) is accepted.

Decomposition:
- `ADD and the other alu_op codes stay in the shared param.v header.
- Add MUL funct3/funct7 decode constants there for the decoder feeding start.
- FSM state encodings are local to this module.
- No sub-module: the shift registers, counter and FSM are small. The operand mux into the ALU lives in the EX-stage top, not here.

Test Plan:
- rs1=3, rs2=5, start pulse → alu_own high cycles 1-3, done in cycle 4, result=15.
- rs1=0x1234, rs2=0, start → done in cycle 1, result=0, alu_own never asserted.
- rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → done in cycle 33, result=0x00000001; busy high cycles 1-33.
- rs1=7, rs2=0x80000000 → done in cycle 33, result=0x80000000; acc updated only on the final iteration.
- rs1=9, rs2=9; second start in cycle 2 with rs1=2, rs2=2 → second start ignored; done in cycle 5, result=81.
- rs1=6, rs2=0xF0 started, flush in cycle 3 → IDLE in cycle 4, no done, result keeps prior value. Repeat with rst in cycle 3 → result=0.

Source files
------------

// File: rtl/alu_mul_seq_pkg.sv
// Shared EX-stage constants: ALU opcodes and RV32M MUL decode fields.
// Imported by the multiply sequencer and by the decoder that raises its start.
package alu_mul_seq_pkg;

    localparam logic [3:0] ALU_NOP  = 4'h0;
    localparam logic [3:0] ALU_ADD  = 4'h1;
    localparam logic [3:0] ALU_SUB  = 4'h2;
    localparam logic [3:0] ALU_AND  = 4'h3;
    localparam logic [3:0] ALU_OR   = 4'h4;
    localparam logic [3:0] ALU_XOR  = 4'h5;
    localparam logic [3:0] ALU_SLL  = 4'h6;
    localparam logic [3:0] ALU_SRL  = 4'h7;
    localparam logic [3:0] ALU_SRA  = 4'h8;
    localparam logic [3:0] ALU_SLT  = 4'h9;
    localparam logic [3:0] ALU_SLTU = 4'hA;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [2:0] FUNCT3_MUL    = 3'b000;

    function automatic logic is_mul(input logic [6:0] opcode,
                                    input logic [6:0] funct7,
                                    input logic [2:0] funct3);
        return (opcode == OPC_OP) && (funct7 == FUNCT7_MULDIV) && (funct3 == FUNCT3_MUL);
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add RV32M MUL sequencer that borrows the shared EX ALU for one ADD per
// iteration; stops early once the remaining multiplier bits are all zero.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             alu_own,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_c
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mc;
    logic [WIDTH-1:0] r_mp;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_res;

    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_mp_shr;
    logic             w_last;
    logic             w_accept;

    assign w_accept  = (r_state == S_IDLE) && start && !flush;
    assign w_acc_nxt = r_mp[0] ? alu_c : r_acc;
    assign w_mp_shr  = r_mp >> 1;
    // The counter bound only matters as a backstop; the empty-multiplier test
    // ends every operation by the final bit anyway.
    assign w_last    = (w_mp_shr == '0) || (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (start) w_state_nxt = (rs2 != '0) ? S_RUN : S_DONE;
                S_RUN:  if (w_last) w_state_nxt = S_DONE;
                S_DONE: w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_mc    <= '0;
            r_mp    <= '0;
            r_cnt   <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_acc <= '0;
                r_mc  <= rs1;
                r_mp  <= rs2;
                r_cnt <= '0;
                if (rs2 == '0) r_res <= '0;
            end else if ((r_state == S_RUN) && !flush) begin
                r_acc <= w_acc_nxt;
                r_mc  <= r_mc << 1;
                r_mp  <= w_mp_shr;
                r_cnt <= r_cnt + 1'b1;
                // Result captured on DONE entry so it is stable while done pulses.
                if (w_last) r_res <= w_acc_nxt;
            end
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE) && !flush;
    assign result  = r_res;
    assign alu_own = (r_state == S_RUN);
    assign alu_op  = alu_own ? ALU_ADD : 4'h0;
    assign alu_a   = alu_own ? r_acc : '0;
    assign alu_b   = alu_own ? r_mc  : '0;

endmodule
